// File: rtl/piso_serial_tx_if.sv
// Upstream word handshake for the framed serial transmitter.
// master = word producer, slave = transmitter.
interface piso_serial_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;

   modport master (
      output data_in,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  data_in,
      input  load_valid,
      output load_ready
   );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out framed transmitter: start, LSB-first data,
// optional even parity, stop. Every output comes straight from a flop.
module piso_serial_tx #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   piso_serial_tx_if.slave   up,
   output logic              serial_out,
   output logic              frame_active,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = $clog2(WIDTH + 1);

   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             par_q, par_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic             ser_q, ser_d;
   logic             done_q, done_d;
   logic             fa_q, fa_d;
   logic             rdy_q, rdy_d;
   logic             bit_end;

   // Frame sequencing: bit timing, data shifting and state advance.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      bit_end   = (cyc_q == CYC_LAST);
      if (state_q == IDLE || bit_end) begin
         cyc_d = '0;
      end else begin
         cyc_d = cyc_q + CYC_ONE;
      end
      unique case (state_q)
         IDLE: begin
            if (up.load_valid) begin
               shreg_d   = up.data_in;
               par_d     = ^up.data_in;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the next state so the flops hold glitch-free levels.
   always_comb begin
      ser_d = 1'b1;
      fa_d  = (state_d != IDLE);
      rdy_d = (state_d == IDLE);
      unique case (state_d)
         START:   ser_d = 1'b0;
         DATA:    ser_d = shreg_d[0];
         PARITY:  ser_d = par_d;
         default: ser_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         cyc_q     <= '0;
         ser_q     <= 1'b1;
         done_q    <= 1'b0;
         fa_q      <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         cyc_q     <= cyc_d;
         ser_q     <= ser_d;
         done_q    <= done_d;
         fa_q      <= fa_d;
         rdy_q     <= rdy_d;
      end
   end

   assign serial_out    = ser_q;
   assign frame_active  = fa_q;
   assign done          = done_q;
   assign up.load_ready = rdy_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three configurations checked against a
// frame model built from the bit-list definition of the frame.
module tb_piso_serial_tx;

   logic clock;
   logic rst_n;
   int   total;
   int   bad;

   piso_serial_tx_if #(.WIDTH(8)) ifa ();
   piso_serial_tx_if #(.WIDTH(8)) ifb ();
   piso_serial_tx_if #(.WIDTH(4)) ifc ();

   logic ser_a, fa_a, dn_a;
   logic ser_b, fa_b, dn_b;
   logic ser_c, fa_c, dn_c;

   piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(0)) dut_a (
      .clock(clock), .reset_n(rst_n), .up(ifa.slave),
      .serial_out(ser_a), .frame_active(fa_a), .done(dn_a));

   piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1)) dut_b (
      .clock(clock), .reset_n(rst_n), .up(ifb.slave),
      .serial_out(ser_b), .frame_active(fa_b), .done(dn_b));

   piso_serial_tx #(.WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(0)) dut_c (
      .clock(clock), .reset_n(rst_n), .up(ifc.slave),
      .serial_out(ser_c), .frame_active(fa_c), .done(dn_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int wid(input int d);
      return (d == 2) ? 4 : 8;
   endfunction

   function automatic int bcy(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic int pen(input int d);
      return (d == 1) ? 1 : 0;
   endfunction

   // {serial_out, frame_active, done, load_ready}
   function automatic logic [3:0] obs(input int d);
      case (d)
         0:       return {ser_a, fa_a, dn_a, ifa.load_ready};
         1:       return {ser_b, fa_b, dn_b, ifb.load_ready};
         default: return {ser_c, fa_c, dn_c, ifc.load_ready};
      endcase
   endfunction

   task automatic drive(input int d, input logic v, input logic [7:0] x);
      case (d)
         0: begin ifa.load_valid = v; ifa.data_in = x; end
         1: begin ifb.load_valid = v; ifb.data_in = x; end
         default: begin ifc.load_valid = v; ifc.data_in = x[3:0]; end
      endcase
   endtask

   // Called after the accept edge. Walks the whole frame, then the done cycle.
   task automatic check_frame(input int d, input logic [7:0] data,
                              input bit chain, input logic [7:0] nxt,
                              input string nm);
      bit         q[$];
      bit         par;
      int         n;
      logic [3:0] o;
      logic [3:0] e;
      par = 1'b0;
      q.push_back(1'b0);
      for (int i = 0; i < wid(d); i++) begin
         q.push_back(data[i]);
         par ^= data[i];
      end
      if (pen(d) != 0) q.push_back(par);
      q.push_back(1'b1);
      n = q.size() * bcy(d);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         o = obs(d);
         e = {q[k / bcy(d)], 1'b1, 1'b0, 1'b0};
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, k, o, e);
         end
         if (chain) drive(d, 1'b1, nxt);
         else drive(d, 1'b0, 8'($urandom));
      end
      @(negedge clock);
      o = obs(d);
      total++;
      if (o !== 4'b1011) begin
         bad++;
         $display("FAIL %s done got=%b want=1011", nm, o);
      end
      if (!chain) begin
         @(negedge clock);
         o = obs(d);
         total++;
         if (o !== 4'b1001) begin
            bad++;
            $display("FAIL %s post got=%b want=1001", nm, o);
         end
      end
   endtask

   task automatic send(input int d, input logic [7:0] w, input string nm);
      @(negedge clock);
      drive(d, 1'b1, w);
      @(posedge clock);
      check_frame(d, w, 1'b0, 8'h00, nm);
   endtask

   task automatic test_reset();
      logic [3:0] o;
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         o = obs(d);
         total++;
         if (o !== 4'b1001) begin
            bad++;
            $display("FAIL reset dut=%0d got=%b want=1001", d, o);
         end
      end
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         o = obs(0);
         total++;
         if (o !== 4'b1001) begin
            bad++;
            $display("FAIL idle cyc=%0d got=%b want=1001", k, o);
         end
      end
   endtask

   task automatic test_single_frame();
      send(0, 8'hA5, "a5");
      for (int i = 0; i < 4; i++) send(0, 8'($urandom), "rand_a");
   endtask

   task automatic test_parity();
      send(1, 8'hA5, "par_a5");
      send(1, 8'h07, "par_07");
      for (int i = 0; i < 4; i++) send(1, 8'($urandom), "rand_b");
   endtask

   task automatic test_back_to_back();
      logic [7:0] w0, w1;
      @(negedge clock);
      drive(0, 1'b1, 8'h3C);
      @(posedge clock);
      check_frame(0, 8'h3C, 1'b1, 8'hC3, "b2b_3c");
      @(posedge clock);
      check_frame(0, 8'hC3, 1'b0, 8'h00, "b2b_c3");
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      @(negedge clock);
      drive(1, 1'b1, w0);
      @(posedge clock);
      check_frame(1, w0, 1'b1, w1, "b2b_b0");
      @(posedge clock);
      check_frame(1, w1, 1'b0, 8'h00, "b2b_b1");
   endtask

   task automatic test_mid_frame_reset();
      logic [3:0] o;
      @(negedge clock);
      drive(0, 1'b1, 8'hFF);
      @(posedge clock);
      for (int k = 0; k < 18; k++) begin
         @(negedge clock);
         drive(0, 1'b0, 8'h00);
      end
      o = obs(0);
      total++;
      if (o !== 4'b1100) begin
         bad++;
         $display("FAIL mid_pre got=%b want=1100", o);
      end
      #2 rst_n = 1'b0;
      #1;
      o = obs(0);
      total++;
      if (o !== 4'b1001) begin
         bad++;
         $display("FAIL mid_rst got=%b want=1001", o);
      end
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         o = obs(0);
         total++;
         if (o !== 4'b1001) begin
            bad++;
            $display("FAIL mid_after cyc=%0d got=%b want=1001", k, o);
         end
      end
   endtask

   task automatic test_bit_cycles_one();
      send(2, 8'h09, "c_9");
      for (int i = 0; i < 4; i++) send(2, 8'($urandom), "rand_c");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      test_reset();
      test_single_frame();
      test_parity();
      test_back_to_back();
      test_mid_frame_reset();
      test_bit_cycles_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
